// File: rtl/peripheral_gpio_wb_if.sv
// Wishbone slave bus bundle for the GPIO block; signal names follow the slave's view (_i = into slave).
interface peripheral_gpio_wb_if #(
    parameter int unsigned WB_ADDR_WIDTH = 32,
    parameter int unsigned WB_DATA_WIDTH = 32
);
    logic                     wb_cyc_i;
    logic                     wb_stb_i;
    logic [WB_ADDR_WIDTH-1:0] wb_adr_i;
    logic [WB_DATA_WIDTH-1:0] wb_dat_i;
    logic [3:0]               wb_sel_i;
    logic                     wb_we_i;
    logic [WB_DATA_WIDTH-1:0] wb_dat_o;
    logic                     wb_ack_o;
    logic                     wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/peripheral_gpio_wb.sv
// Wishbone-slave GPIO: per-pin out/oe/aux muxing, 2-flop synchronized inputs, edge-triggered interrupts.
module peripheral_gpio_wb #(
    parameter int unsigned WB_DATA_WIDTH = 32,
    parameter int unsigned WB_ADDR_WIDTH = 32,
    parameter int unsigned GPIO_WIDTH    = 32
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    peripheral_gpio_wb_if.slave   wb,
    output logic                  wb_inta_o,
    input  logic [GPIO_WIDTH-1:0] aux_i,
    input  logic [GPIO_WIDTH-1:0] ext_pad_i,
    output logic [GPIO_WIDTH-1:0] ext_pad_o,
    output logic [GPIO_WIDTH-1:0] ext_padoe_o
);

    typedef enum logic [2:0] {
        REG_IN    = 3'd0,
        REG_OUT   = 3'd1,
        REG_OE    = 3'd2,
        REG_INTE  = 3'd3,
        REG_PTRIG = 3'd4,
        REG_AUX   = 3'd5,
        REG_CTRL  = 3'd6,
        REG_INTS  = 3'd7
    } reg_sel_e;

    logic                     ack_q,   ack_d;
    logic [WB_DATA_WIDTH-1:0] dat_q,   dat_d;
    logic [GPIO_WIDTH-1:0]    out_q,   out_d;
    logic [GPIO_WIDTH-1:0]    oe_q,    oe_d;
    logic [GPIO_WIDTH-1:0]    inte_q,  inte_d;
    logic [GPIO_WIDTH-1:0]    ptrig_q, ptrig_d;
    logic [GPIO_WIDTH-1:0]    aux_q,   aux_d;
    logic [GPIO_WIDTH-1:0]    ints_q,  ints_d;
    logic                     ctrl_inte_q, ctrl_inte_d;
    logic                     inta_q,  inta_d;
    logic [GPIO_WIDTH-1:0]    sync1_q, sync1_d;
    logic [GPIO_WIDTH-1:0]    in_q,    in_d;
    logic [GPIO_WIDTH-1:0]    prev_q,  prev_d;

    reg_sel_e                 reg_sel;
    logic                     req;
    logic                     wr;
    logic [WB_DATA_WIDTH-1:0] sel_mask;
    logic [GPIO_WIDTH-1:0]    wmask;
    logic [GPIO_WIDTH-1:0]    wdat;
    logic [WB_DATA_WIDTH-1:0] rdata;
    logic [GPIO_WIDTH-1:0]    rise;
    logic [GPIO_WIDTH-1:0]    fall;
    logic [GPIO_WIDTH-1:0]    event_set;
    logic                     unused_adr;

    function automatic logic [GPIO_WIDTH-1:0] merge(
        input logic [GPIO_WIDTH-1:0] old_v,
        input logic [GPIO_WIDTH-1:0] new_v,
        input logic [GPIO_WIDTH-1:0] mask
    );
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign reg_sel    = reg_sel_e'(wb.wb_adr_i[4:2]);
    assign unused_adr = ^{wb.wb_adr_i[WB_ADDR_WIDTH-1:5], wb.wb_adr_i[1:0]};

    // A request is only accepted when no ack is outstanding, giving one ack per two cycles back-to-back.
    assign req = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr  = req & wb.wb_we_i;

    always_comb begin
        sel_mask = '0;
        for (int unsigned b = 0; b < WB_DATA_WIDTH / 8; b++) begin
            sel_mask[8*b +: 8] = {8{wb.wb_sel_i[b]}};
        end
    end

    assign wmask = sel_mask[GPIO_WIDTH-1:0];
    assign wdat  = wb.wb_dat_i[GPIO_WIDTH-1:0];

    assign rise      = in_q & ~prev_q;
    assign fall      = ~in_q & prev_q;
    assign event_set = inte_q & ((ptrig_q & rise) | (~ptrig_q & fall));

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_IN:    rdata[GPIO_WIDTH-1:0] = in_q;
            REG_OUT:   rdata[GPIO_WIDTH-1:0] = out_q;
            REG_OE:    rdata[GPIO_WIDTH-1:0] = oe_q;
            REG_INTE:  rdata[GPIO_WIDTH-1:0] = inte_q;
            REG_PTRIG: rdata[GPIO_WIDTH-1:0] = ptrig_q;
            REG_AUX:   rdata[GPIO_WIDTH-1:0] = aux_q;
            REG_CTRL:  rdata[1:0]            = {|ints_q, ctrl_inte_q};
            REG_INTS:  rdata[GPIO_WIDTH-1:0] = ints_q;
            default:   rdata                 = '0;
        endcase
    end

    always_comb begin
        ack_d       = req;
        dat_d       = req ? rdata : '0;
        out_d       = out_q;
        oe_d        = oe_q;
        inte_d      = inte_q;
        ptrig_d     = ptrig_q;
        aux_d       = aux_q;
        ctrl_inte_d = ctrl_inte_q;
        ints_d      = ints_q;
        sync1_d     = ext_pad_i;
        in_d        = sync1_q;
        prev_d      = in_q;
        inta_d      = ctrl_inte_q & (|ints_q);

        if (wr) begin
            case (reg_sel)
                REG_OUT:   out_d   = merge(out_q,   wdat, wmask);
                REG_OE:    oe_d    = merge(oe_q,    wdat, wmask);
                REG_INTE:  inte_d  = merge(inte_q,  wdat, wmask);
                REG_PTRIG: ptrig_d = merge(ptrig_q, wdat, wmask);
                REG_AUX:   aux_d   = merge(aux_q,   wdat, wmask);
                REG_CTRL:  if (wb.wb_sel_i[0]) ctrl_inte_d = wb.wb_dat_i[0];
                REG_INTS:  ints_d  = merge(ints_q,  wdat, wmask);
                default:   ;
            endcase
        end

        // Hardware events are OR-ed after the software write so a same-cycle set always wins.
        ints_d = ints_d | event_set;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            out_q       <= '0;
            oe_q        <= '0;
            inte_q      <= '0;
            ptrig_q     <= '0;
            aux_q       <= '0;
            ints_q      <= '0;
            ctrl_inte_q <= 1'b0;
            inta_q      <= 1'b0;
            sync1_q     <= '0;
            in_q        <= '0;
            prev_q      <= '0;
        end else begin
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            out_q       <= out_d;
            oe_q        <= oe_d;
            inte_q      <= inte_d;
            ptrig_q     <= ptrig_d;
            aux_q       <= aux_d;
            ints_q      <= ints_d;
            ctrl_inte_q <= ctrl_inte_d;
            inta_q      <= inta_d;
            sync1_q     <= sync1_d;
            in_q        <= in_d;
            prev_q      <= prev_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_err_o = 1'b0;
    assign wb_inta_o   = inta_q;
    assign ext_pad_o   = (aux_q & aux_i) | (~aux_q & out_q);
    assign ext_padoe_o = oe_q;

endmodule

// File: tb/tb_peripheral_gpio_wb.sv
// Self-checking bench for peripheral_gpio_wb: directed vector table, corner-case sequences, randomized model check.
module tb_peripheral_gpio_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] aux;
    logic [31:0] pad_in;
    logic [31:0] pad_o;
    logic [31:0] padoe;
    logic        inta;

    always #5 clk = ~clk;

    peripheral_gpio_wb_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) bus ();

    peripheral_gpio_wb #(
        .WB_DATA_WIDTH(32),
        .WB_ADDR_WIDTH(32),
        .GPIO_WIDTH   (32)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst_n),
        .wb         (bus),
        .wb_inta_o  (inta),
        .aux_i      (aux),
        .ext_pad_i  (pad_in),
        .ext_pad_o  (pad_o),
        .ext_padoe_o(padoe)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] adr;
        bit          we;
        logic [31:0] wd;
        logic [3:0]  sel;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          chk_pads;
        logic [31:0] exp_pad;
        logic [31:0] exp_oe;
    } vec_t;

    vec_t tbl [22];

    // Reference model state
    logic [31:0] m_out, m_oe, m_inte, m_ptrig, m_aux, m_ints, m_in;
    logic        m_ctrl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bus_idle();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_sel_i = '0;
    endtask

    // Called at a negedge; returns at a negedge after the ack has dropped.
    task automatic xfer(input logic [31:0] adr, input bit we, input logic [31:0] wd,
                        input logic [3:0] sel, output logic [31:0] rd);
        int cnt;
        bus.wb_adr_i = adr;
        bus.wb_we_i  = we;
        bus.wb_dat_i = wd;
        bus.wb_sel_i = sel;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (bus.wb_ack_o !== 1'b1 && cnt < 8);
        check("ack_latency", cnt, 1);
        check("err_low", {31'b0, bus.wb_err_o}, 32'h0);
        rd = bus.wb_dat_o;
        bus_idle();
        @(negedge clk);
        check("ack_single_pulse", {31'b0, bus.wb_ack_o}, 32'h0);
    endtask

    task automatic wr32(input logic [31:0] adr, input logic [31:0] wd);
        logic [31:0] dummy;
        xfer(adr, 1'b1, wd, 4'hF, dummy);
    endtask

    task automatic rd_check(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        xfer(adr, 1'b0, 32'h0, 4'hF, rd);
        check(name, rd, exp);
    endtask

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] wd,
                                               input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_reg(input int k);
        case (k)
            0:       return m_in;
            1:       return m_out;
            2:       return m_oe;
            3:       return m_inte;
            4:       return m_ptrig;
            5:       return m_aux;
            6:       return {30'b0, |m_ints, m_ctrl};
            default: return m_ints;
        endcase
    endfunction

    initial begin
        logic [31:0] rd;
        logic [3:0]  pat;

        tbl[0]  = '{32'h00, 0, 32'h0,        4'hF, 1, 32'h0,        1, 32'h0,        32'h0};
        tbl[1]  = '{32'h04, 0, 32'h0,        4'hF, 1, 32'h0,        1, 32'h0,        32'h0};
        tbl[2]  = '{32'h08, 0, 32'h0,        4'hF, 1, 32'h0,        1, 32'h0,        32'h0};
        tbl[3]  = '{32'h0C, 0, 32'h0,        4'hF, 1, 32'h0,        1, 32'h0,        32'h0};
        tbl[4]  = '{32'h10, 0, 32'h0,        4'hF, 1, 32'h0,        1, 32'h0,        32'h0};
        tbl[5]  = '{32'h14, 0, 32'h0,        4'hF, 1, 32'h0,        1, 32'h0,        32'h0};
        tbl[6]  = '{32'h18, 0, 32'h0,        4'hF, 1, 32'h0,        1, 32'h0,        32'h0};
        tbl[7]  = '{32'h1C, 0, 32'h0,        4'hF, 1, 32'h0,        1, 32'h0,        32'h0};
        tbl[8]  = '{32'h08, 1, 32'hFFFFFFFF, 4'hF, 0, 32'h0,        0, 32'h0,        32'h0};
        tbl[9]  = '{32'h04, 1, 32'hA5A55A5A, 4'hF, 0, 32'h0,        1, 32'hA5A55A5A, 32'hFFFFFFFF};
        tbl[10] = '{32'h04, 0, 32'h0,        4'hF, 1, 32'hA5A55A5A, 0, 32'h0,        32'h0};
        tbl[11] = '{32'h08, 0, 32'h0,        4'hF, 1, 32'hFFFFFFFF, 0, 32'h0,        32'h0};
        tbl[12] = '{32'h04, 1, 32'h0,        4'hF, 0, 32'h0,        0, 32'h0,        32'h0};
        tbl[13] = '{32'h04, 1, 32'h12345678, 4'h2, 0, 32'h0,        0, 32'h0,        32'h0};
        tbl[14] = '{32'h04, 0, 32'h0,        4'hF, 1, 32'h00005600, 1, 32'h00005600, 32'hFFFFFFFF};
        tbl[15] = '{32'h14, 1, 32'h0000FFFF, 4'hF, 0, 32'h0,        0, 32'h0,        32'h0};
        tbl[16] = '{32'h04, 1, 32'hFFFF0000, 4'hF, 0, 32'h0,        1, 32'hFFFFAAAA, 32'hFFFFFFFF};
        tbl[17] = '{32'h14, 0, 32'h0,        4'hF, 1, 32'h0000FFFF, 0, 32'h0,        32'h0};
        tbl[18] = '{32'h00, 1, 32'hDEADBEEF, 4'hF, 0, 32'h0,        0, 32'h0,        32'h0};
        tbl[19] = '{32'h00, 0, 32'h0,        4'hF, 1, 32'h0,        0, 32'h0,        32'h0};
        tbl[20] = '{32'h04, 1, 32'hFFFFFFFF, 4'h0, 0, 32'h0,        0, 32'h0,        32'h0};
        tbl[21] = '{32'h04, 0, 32'h0,        4'hF, 1, 32'hFFFF0000, 1, 32'hFFFFAAAA, 32'hFFFFFFFF};

        bus_idle();
        aux    = '0;
        pad_in = '0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack",   {31'b0, bus.wb_ack_o}, 32'h0);
        check("rst_dat",   bus.wb_dat_o, 32'h0);
        check("rst_pad_o", pad_o, 32'h0);
        check("rst_padoe", padoe, 32'h0);
        check("rst_inta",  {31'b0, inta}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        aux = 32'h0000AAAA;
        for (int i = 0; i < 22; i++) begin
            xfer(tbl[i].adr, tbl[i].we, tbl[i].wd, tbl[i].sel, rd);
            if (tbl[i].chk_rd) check("tbl_read", rd, tbl[i].exp_rd);
            if (tbl[i].chk_pads) begin
                check("tbl_pad_o", pad_o, tbl[i].exp_pad);
                check("tbl_padoe", padoe, tbl[i].exp_oe);
            end
        end

        // Input synchronizer latency and address aliasing
        pad_in = 32'h0F0F0F0F;
        @(negedge clk);
        rd_check("in_too_early", 32'h00, 32'h0);
        rd_check("in_synced",    32'h00, 32'h0F0F0F0F);
        rd_check("in_alias_20",  32'h20, 32'h0F0F0F0F);

        // Back-to-back request: ack every other cycle
        bus.wb_adr_i = 32'h0;
        bus.wb_sel_i = 4'hF;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat = {pat[2:0], bus.wb_ack_o};
        end
        bus_idle();
        @(negedge clk);
        check("b2b_ack_pattern", {28'b0, pat}, 32'h0000000A);

        // Interrupt flow
        pad_in = '0;
        repeat (4) @(negedge clk);
        wr32(32'h0C, 32'h1);
        wr32(32'h10, 32'h1);
        wr32(32'h18, 32'h1);
        check("inta_idle", {31'b0, inta}, 32'h0);
        pad_in = 32'h1;
        repeat (5) @(negedge clk);
        rd_check("ints_rise", 32'h1C, 32'h1);
        rd_check("ctrl_pend", 32'h18, 32'h3);
        check("inta_set", {31'b0, inta}, 32'h1);
        wr32(32'h0C, 32'h0);
        rd_check("ints_kept_inte_off", 32'h1C, 32'h1);
        wr32(32'h0C, 32'h1);
        wr32(32'h1C, 32'h0);
        check("inta_cleared", {31'b0, inta}, 32'h0);
        rd_check("ctrl_no_pend", 32'h18, 32'h1);
        wr32(32'h10, 32'h0);
        pad_in = 32'h0;
        repeat (5) @(negedge clk);
        rd_check("ints_fall", 32'h1C, 32'h1);
        check("inta_fall", {31'b0, inta}, 32'h1);

        // Same-cycle hardware set and software clear: the set must win
        wr32(32'h1C, 32'h0);
        pad_in = 32'h1;
        repeat (5) @(negedge clk);
        rd_check("ints_rise_ignored", 32'h1C, 32'h0);
        pad_in = 32'h0;
        repeat (2) @(negedge clk);
        wr32(32'h1C, 32'h0);
        rd_check("ints_set_wins", 32'h1C, 32'h1);

        // Reset during a write: no partial update, ack/data cleared
        repeat (3) @(negedge clk);
        bus.wb_adr_i = 32'h04;
        bus.wb_we_i  = 1'b1;
        bus.wb_dat_i = 32'h0000FFFF;
        bus.wb_sel_i = 4'hF;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ack",   {31'b0, bus.wb_ack_o}, 32'h0);
        check("midrst_dat",   bus.wb_dat_o, 32'h0);
        check("midrst_pad_o", pad_o, 32'h0);
        check("midrst_padoe", padoe, 32'h0);
        check("midrst_inta",  {31'b0, inta}, 32'h0);
        bus_idle();
        rst_n = 1'b1;
        @(negedge clk);
        rd_check("midrst_out",  32'h04, 32'h0);
        rd_check("midrst_ints", 32'h1C, 32'h0);

        // Randomized register/pad traffic against the reference model
        m_out = '0; m_oe = '0; m_inte = '0; m_ptrig = '0; m_aux = '0; m_ints = '0; m_in = '0;
        m_ctrl = 1'b0;
        for (int it = 0; it < 30; it++) begin
            logic [31:0] r, wd, newpad, ev, adr;
            logic [3:0]  sel;
            int          idx;
            r   = $urandom;
            idx = $urandom_range(0, 7);
            wd  = $urandom;
            sel = 4'($urandom_range(0, 15));
            adr = {r[31:5], 3'(idx), 2'b00};
            xfer(adr, 1'b1, wd, sel, rd);
            case (idx)
                1: m_out   = byte_merge(m_out,   wd, sel);
                2: m_oe    = byte_merge(m_oe,    wd, sel);
                3: m_inte  = byte_merge(m_inte,  wd, sel);
                4: m_ptrig = byte_merge(m_ptrig, wd, sel);
                5: m_aux   = byte_merge(m_aux,   wd, sel);
                6: if (sel[0]) m_ctrl = wd[0];
                7: m_ints  = byte_merge(m_ints,  wd, sel);
                default: ;
            endcase
            aux    = $urandom;
            newpad = ($urandom_range(0, 3) == 0) ? m_in : $urandom;
            pad_in = newpad;
            repeat (5) @(negedge clk);
            ev = m_inte & ((m_ptrig & ~m_in & newpad) | (~m_ptrig & m_in & ~newpad));
            m_ints = m_ints | ev;
            m_in   = newpad;
            for (int k = 0; k < 8; k++) begin
                r = $urandom;
                xfer({r[31:5], 3'(k), 2'b00}, 1'b0, 32'h0, 4'hF, rd);
                check("rand_read", rd, model_reg(k));
            end
            check("rand_pad_o", pad_o, (m_aux & aux) | (~m_aux & m_out));
            check("rand_padoe", padoe, m_oe);
            check("rand_inta",  {31'b0, inta}, {31'b0, m_ctrl & (|m_ints)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
